// File: rtl/prim_fifo_ptr_pkg.sv
// Shared definitions for the FIFO pointer manager: width derivation, the
// pointer-to-occupancy helper and the error-cause encoding.
package prim_fifo_ptr_pkg;

    typedef enum logic [1:0] {
        ErrOverflow  = 2'd0,
        ErrUnderflow = 2'd1,
        ErrIntegrity = 2'd2
    } err_cause_e;

    localparam int unsigned NumErrCauses = 3;

    // Index bits plus one wrap bit.
    function automatic int unsigned calc_ptr_w(int unsigned depth);
        return 32'($clog2(depth)) + 32'd1;
    endfunction

    function automatic int unsigned calc_depth_w(int unsigned depth);
        return 32'($clog2(depth + 1));
    endfunction

    function automatic logic [31:0] ptr_depth(logic [31:0] wptr, logic [31:0] rptr,
                                              int unsigned depth);
        int unsigned iw;
        logic [31:0] mask;
        logic [31:0] widx;
        logic [31:0] ridx;
        iw   = calc_ptr_w(depth) - 32'd1;
        mask = (32'd1 << iw) - 32'd1;
        widx = wptr & mask;
        ridx = rptr & mask;
        if (((wptr >> iw) & 32'd1) == ((rptr >> iw) & 32'd1)) begin
            return widx - ridx;
        end
        return depth - ridx + widx;
    endfunction

endpackage

// File: rtl/prim_fifo_sync_ptrs_if.sv
// Request/status bundle between a FIFO wrapper and its pointer manager.
interface prim_fifo_sync_ptrs_if
    import prim_fifo_ptr_pkg::*;
#(
    parameter int unsigned Depth = 4
);
    localparam int unsigned PtrW   = calc_ptr_w(Depth);
    localparam int unsigned DepthW = calc_depth_w(Depth);

    logic              clr;
    logic              incr_wptr;
    logic              incr_rptr;
    logic [PtrW-1:0]   wptr;
    logic [PtrW-1:0]   rptr;
    logic [DepthW-1:0] depth;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              push_ok;
    logic              pop_ok;
    logic              err;

    modport master (
        output clr, incr_wptr, incr_rptr,
        input  wptr, rptr, depth, full, empty, almost_full, almost_empty, push_ok, pop_ok, err
    );

    modport slave (
        input  clr, incr_wptr, incr_rptr,
        output wptr, rptr, depth, full, empty, almost_full, almost_empty, push_ok, pop_ok, err
    );

endinterface

// File: rtl/prim_fifo_ptr_cnt.sv
// One wrap-bit pointer counting 0..Depth-1 per lap, with an optional inverted
// shadow copy and index range check for integrity detection.
module prim_fifo_ptr_cnt
    import prim_fifo_ptr_pkg::*;
#(
    parameter int unsigned Depth  = 4,
    parameter bit          Secure = 1'b0,
    localparam int unsigned PtrW  = calc_ptr_w(Depth)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            incr_i,
    output logic [PtrW-1:0] ptr_o,
    output logic            err_o
);
    localparam int unsigned IdxW = PtrW - 1;

    function automatic logic [PtrW-1:0] ptr_next(logic [PtrW-1:0] ptr, logic clr, logic incr);
        logic [PtrW-1:0] nxt;
        nxt = ptr;
        if (clr) begin
            nxt = '0;
        end else if (incr) begin
            if (32'(ptr[IdxW-1:0]) == Depth - 32'd1) begin
                nxt = {~ptr[PtrW-1], {IdxW{1'b0}}};
            end else begin
                nxt = {ptr[PtrW-1], ptr[IdxW-1:0] + IdxW'(1)};
            end
        end
        return nxt;
    endfunction

    logic [PtrW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_next(ptr_q, clr_i, incr_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

    if (Secure) begin : gen_shadow
        logic [PtrW-1:0] shadow_q, shadow_d;

        // Shadow advances from its own value so a flip in either copy stays visible.
        always_comb begin
            shadow_d = ~ptr_next(~shadow_q, clr_i, incr_i);
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                shadow_q <= '1;
            end else begin
                shadow_q <= shadow_d;
            end
        end

        assign err_o = (ptr_q != ~shadow_q) || (32'(ptr_q[IdxW-1:0]) >= Depth);
    end else begin : gen_no_shadow
        assign err_o = 1'b0;
    end

endmodule

// File: rtl/prim_fifo_sync_ptrs.sv
// Pointer and occupancy manager for a synchronous FIFO of arbitrary depth:
// request acceptance, flag decode, optional redundant occupancy, sticky error.
module prim_fifo_sync_ptrs
    import prim_fifo_ptr_pkg::*;
#(
    parameter int unsigned Depth        = 4,
    parameter int unsigned AfullThresh  = Depth - 1,
    parameter int unsigned AemptyThresh = 1,
    parameter bit          Secure       = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    prim_fifo_sync_ptrs_if.slave bus
);
    localparam int unsigned PtrW   = calc_ptr_w(Depth);
    localparam int unsigned DepthW = calc_depth_w(Depth);
    localparam int unsigned IdxW   = PtrW - 1;

    logic [PtrW-1:0]   wptr, rptr;
    logic [DepthW-1:0] depth;
    logic              full, empty, push_ok, pop_ok;
    logic              wptr_err, rptr_err, cnt_err;
    logic [NumErrCauses-1:0] err_cause;
    logic              err_q, err_d;

    prim_fifo_ptr_cnt #(
        .Depth  (Depth),
        .Secure (Secure)
    ) u_wptr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (bus.clr),
        .incr_i (push_ok),
        .ptr_o  (wptr),
        .err_o  (wptr_err)
    );

    prim_fifo_ptr_cnt #(
        .Depth  (Depth),
        .Secure (Secure)
    ) u_rptr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (bus.clr),
        .incr_i (pop_ok),
        .ptr_o  (rptr),
        .err_o  (rptr_err)
    );

    assign depth = DepthW'(ptr_depth(32'(wptr), 32'(rptr), Depth));
    assign full  = (wptr[IdxW-1:0] == rptr[IdxW-1:0]) && (wptr[PtrW-1] != rptr[PtrW-1]);
    assign empty = (wptr == rptr);

    // A pop on empty is refused even with a concurrent push; a full FIFO only
    // takes a push when a pop frees a slot in the same cycle.
    assign pop_ok  = bus.incr_rptr & ~empty;
    assign push_ok = bus.incr_wptr & (~full | pop_ok);

    if (Secure) begin : gen_secure
        logic [DepthW-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (bus.clr) begin
                cnt_d = '0;
            end else if (push_ok && !pop_ok) begin
                cnt_d = cnt_q + DepthW'(1);
            end else if (pop_ok && !push_ok) begin
                cnt_d = cnt_q - DepthW'(1);
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt_err = (cnt_q != depth);
    end else begin : gen_plain
        assign cnt_err = 1'b0;
    end

    always_comb begin
        err_cause               = '0;
        err_cause[ErrOverflow]  = bus.incr_wptr & ~push_ok;
        err_cause[ErrUnderflow] = bus.incr_rptr & ~pop_ok;
        err_cause[ErrIntegrity] = wptr_err | rptr_err | cnt_err;
        err_d                   = err_q | (|err_cause);
    end

    // Sticky: only reset clears it, clr deliberately leaves it alone.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.wptr         = wptr;
    assign bus.rptr         = rptr;
    assign bus.depth        = depth;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (32'(depth) >= AfullThresh);
    assign bus.almost_empty = (32'(depth) <= AemptyThresh);
    assign bus.push_ok      = push_ok;
    assign bus.pop_ok       = pop_ok;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_prim_fifo_sync_ptrs.sv
// Drives a Depth=5 and a Depth=8 secure instance with shared stimulus and
// checks every cycle against a lap-counter occupancy model via scoreboards.
module tb_prim_fifo_sync_ptrs;
    import prim_fifo_ptr_pkg::*;

    typedef struct {
        int wptr;
        int rptr;
        int depth;
        bit full;
        bit empty;
        bit afull;
        bit aempty;
        bit push_ok;
        bit pop_ok;
        bit err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic push = 1'b0;
    logic pop = 1'b0;
    logic [3:0] force_val;
    bit   rel_pending = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prim_fifo_sync_ptrs_if #(.Depth(5)) bus5 ();
    prim_fifo_sync_ptrs_if #(.Depth(8)) bus8 ();

    assign bus5.clr = clr;
    assign bus5.incr_wptr = push;
    assign bus5.incr_rptr = pop;
    assign bus8.clr = clr;
    assign bus8.incr_wptr = push;
    assign bus8.incr_rptr = pop;

    prim_fifo_sync_ptrs #(
        .Depth(5), .AfullThresh(4), .AemptyThresh(1), .Secure(1'b1)
    ) dut5 (
        .clk_i(clk), .rst_i(rst), .bus(bus5)
    );

    prim_fifo_sync_ptrs #(
        .Depth(8), .AfullThresh(6), .AemptyThresh(2), .Secure(1'b1)
    ) dut8 (
        .clk_i(clk), .rst_i(rst), .bus(bus8)
    );

    // Model: pushes/pops counted modulo two laps, occupancy as a plain integer.
    int  md[2]  = '{5, 8};
    int  maf[2] = '{4, 6};
    int  mae[2] = '{1, 2};
    int  wc[2];
    int  rc[2];
    int  cnt[2];
    bit  merr[2];
    exp_t q5[$];
    exp_t q8[$];

    function automatic int enc_ptr(int c, int d);
        return ((c >= d) ? (1 << $clog2(d)) : 0) + (c % d);
    endfunction

    function automatic exp_t build(int i, bit pu, bit po);
        exp_t e;
        e.wptr    = enc_ptr(wc[i], md[i]);
        e.rptr    = enc_ptr(rc[i], md[i]);
        e.depth   = cnt[i];
        e.full    = (cnt[i] == md[i]);
        e.empty   = (cnt[i] == 0);
        e.afull   = (cnt[i] >= maf[i]);
        e.aempty  = (cnt[i] <= mae[i]);
        e.pop_ok  = po && (cnt[i] > 0);
        e.push_ok = pu && ((cnt[i] < md[i]) || e.pop_ok);
        e.err     = merr[i];
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            wc[i] = 0; rc[i] = 0; cnt[i] = 0; merr[i] = 1'b0;
        end
    endtask

    task automatic model_step(bit pu, bit po, bit cl);
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            e = build(i, pu, po);
            if (i == 0) q5.push_back(e); else q8.push_back(e);
            if ((pu && !e.push_ok) || (po && !e.pop_ok)) merr[i] = 1'b1;
            if (cl) begin
                wc[i] = 0; rc[i] = 0; cnt[i] = 0;
            end else begin
                if (e.push_ok) begin wc[i] = (wc[i] + 1) % (2 * md[i]); cnt[i]++; end
                if (e.pop_ok) begin rc[i] = (rc[i] + 1) % (2 * md[i]); cnt[i]--; end
            end
        end
    endtask

    // rs asserts reset asynchronously mid-cycle, ahead of the monitor sample.
    task automatic cycle(bit pu, bit po, bit cl, bit rs);
        @(posedge clk);
        #1;
        if (rel_pending) begin
            release dut5.u_wptr.gen_shadow.shadow_q;
            rel_pending = 1'b0;
        end
        rst = 1'b0;
        push = pu; pop = po; clr = cl;
        if (rs) begin
            #1 rst = 1'b1;
            model_reset();
            q5.push_back(build(0, pu, po));
            q8.push_back(build(1, pu, po));
        end else begin
            model_step(pu, po, cl);
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(string tag, exp_t e, logic [31:0] wp, logic [31:0] rp, logic [31:0] dp,
                       logic fu, logic em, logic af, logic ae, logic pk, logic qk, logic er);
        chk({tag, " wptr"}, wp, e.wptr);
        chk({tag, " rptr"}, rp, e.rptr);
        chk({tag, " depth"}, dp, e.depth);
        chk({tag, " full"}, 32'(fu), 32'(e.full));
        chk({tag, " empty"}, 32'(em), 32'(e.empty));
        chk({tag, " almost_full"}, 32'(af), 32'(e.afull));
        chk({tag, " almost_empty"}, 32'(ae), 32'(e.aempty));
        chk({tag, " push_ok"}, 32'(pk), 32'(e.push_ok));
        chk({tag, " pop_ok"}, 32'(qk), 32'(e.pop_ok));
        chk({tag, " err"}, 32'(er), 32'(e.err));
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (q5.size() > 0) begin
                cmp("d5", q5.pop_front(), 32'(bus5.wptr), 32'(bus5.rptr), 32'(bus5.depth),
                    bus5.full, bus5.empty, bus5.almost_full, bus5.almost_empty,
                    bus5.push_ok, bus5.pop_ok, bus5.err);
            end
            if (q8.size() > 0) begin
                cmp("d8", q8.pop_front(), 32'(bus8.wptr), 32'(bus8.rptr), 32'(bus8.depth),
                    bus8.full, bus8.empty, bus8.almost_full, bus8.almost_empty,
                    bus8.push_ok, bus8.pop_ok, bus8.err);
            end
        end
    end

    initial begin : stimulus
        int p_push;
        int p_pop;
        model_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Fill to Depth=5 (wrap on d5), pass-through on full, then overflow.
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        // clr keeps the sticky error.
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Threshold sweep on d8, drain, then underflow with concurrent push.
        repeat (8) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (8) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Integrity: corrupt the d5 write shadow for one edge.
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0; push = 1'b0; pop = 1'b0; clr = 1'b0;
        force_val = 4'(~enc_ptr(wc[0], md[0])) ^ 4'b0001;
        force dut5.u_wptr.gen_shadow.shadow_q = force_val;
        rel_pending = 1'b1;
        model_step(1'b0, 1'b0, 1'b0);
        merr[0] = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Randomised phases biased toward filling, then draining.
        for (int n = 0; n < 600; n++) begin
            p_push = ((n / 75) % 2 == 0) ? 75 : 35;
            p_pop  = ((n / 75) % 2 == 0) ? 35 : 75;
            cycle(($urandom_range(0, 99) < 32'(p_push)),
                  ($urandom_range(0, 99) < 32'(p_pop)),
                  ($urandom_range(0, 99) < 3),
                  (n % 97 == 50));
        end

        repeat (3) @(posedge clk);
        chk("scoreboard d5 drained", 32'(q5.size()), 0);
        chk("scoreboard d8 drained", 32'(q8.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
